seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse-operation companion to the combinational add/sub datapath.
- Computes quotient and remainder one bit per clock using the same subtract-mode trial (a + ~b + 1) as the add/sub block.
- Sits beside the arithmetic blocks as a multi-cycle unit with a start/busy/done handshake for a controller.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; accepted on a clk edge when busy=0
- dividend  input  WIDTH  unsigned dividend, sampled at acceptance
- divisor  input  WIDTH  unsigned divisor, sampled at acceptance
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag for the last accepted operation

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; working registers and counter cleared. Reset asserted mid-operation aborts it immediately, with no done pulse.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- Acceptance: start=1 at an edge while in IDLE or DONE. Start during RUN is ignored, with no queuing.
- On acceptance with divisor!=0:
  - load working quotient Q=dividend, partial remainder R=0 (WIDTH+1 bits), D=divisor, count=0.
  - Next state is RUN.
- On acceptance with divisor==0:
  - Next state is DONE directly.
  - At that edge: quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN iteration, one per edge, WIDTH edges total:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' + ~{1'b0,D} + 1, i.e. a subtract-mode add at WIDTH+1 bits.
  - If T MSB=0 (non-negative): R=T and Q={Q[WIDTH-2:0],1}.
  - Otherwise: R=R' and Q={Q[WIDTH-2:0],0}.
  - count increments; at the edge performing iteration WIDTH (count==WIDTH-1), next state is DONE.
  - At that same edge: quotient=final Q, remainder=final R[WIDTH-1:0], div_by_zero=0.
- DONE lasts exactly one cycle and then goes to IDLE, unless a new start is accepted (then LOAD→RUN as above).
- Latency: start accepted at edge k. The normal case gives done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles. The divide-by-zero case gives done high in the cycle after edge k.
- quotient, remainder and div_by_zero hold their last result through IDLE and through a subsequent RUN until the next completion.
- Inputs are don't-care outside the acceptance edge; changing them during RUN has no effect.
- Invariant checked by bench: dividend == quotient*divisor + remainder, and remainder < divisor (divisor!=0).

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start 1 cycle -> busy high 4 cycles, then done pulse with quotient=4, remainder=1, div_by_zero=0.
- WIDTH=4, 15/1 -> quotient=15, remainder=0; 7/9 -> quotient=0, remainder=7; 0/5 -> quotient=0, remainder=0.
- WIDTH=4, 9/0 -> done in cycle after acceptance, quotient=4'hF, remainder=9, div_by_zero=1, busy never high.
- Start pulsed again during RUN with 2/1 -> ignored; first operation 13/3 completes with 4/1. Then start asserted in the DONE cycle with 14/4 -> accepted back-to-back, result 3/2.
- rst asserted at iteration 2 of 13/3 -> outputs all 0 asynchronously, no done. A later 6/2 completes with quotient=3, remainder=0.
- WIDTH=8, 255/16 -> quotient=15, remainder=15 after 9 cycles. Random 1000 operands -> invariant holds.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// subtract-mode trial (a + ~b + 1), with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | iterating, one quotient bit per edge (busy=1)
// DONE  | one-cycle result pulse (done=1); a new start may be accepted here
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] q_work;
    logic [WIDTH:0]   r_work;
    logic [WIDTH-1:0] d_work;
    logic [CW-1:0]    count;

    logic             accept;
    logic             iterate;
    logic             finish;
    logic             zero_div;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    assign zero_div = (divisor == '0);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                iterate = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Trial subtraction: a negative result (MSB set) means the divisor did not fit.
    always_comb begin
        r_shift = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
        trial   = r_shift + ~{1'b0, d_work} + (WIDTH+1)'(1);
        if (!trial[WIDTH]) begin
            r_step = trial;
            q_step = {q_work[WIDTH-2:0], 1'b1};
        end else begin
            r_step = r_shift;
            q_step = {q_work[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_work      <= '0;
            r_work      <= '0;
            d_work      <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept && !zero_div) begin
                q_work <= dividend;
                r_work <= '0;
                d_work <= divisor;
                count  <= '0;
            end
            if (accept && zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
            if (iterate) begin
                q_work <= q_step;
                r_work <= r_step;
                count  <= count + CW'(1);
            end
            if (finish) begin
                quotient    <= q_step;
                remainder   <= r_step[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: drivers push expected results, per-instance
// monitors pop and compare on every done pulse (WIDTH=4 and WIDTH=8 instances).
module tb_seq_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic [7:0] dd;
        logic [7:0] dv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] dd4 = '0, dv4 = '0;
    logic       busy4, done4, dz4;
    logic [3:0] quotient4, remainder4;

    logic       start8 = 1'b0;
    logic [7:0] dd8 = '0, dv8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] quotient8, remainder8;

    int   total = 0;
    int   bad = 0;
    exp_t sb4[$];
    exp_t sb8[$];
    exp_t e4, e8;

    seq_divider #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dd4), .divisor(dv4),
        .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
        .div_by_zero(dz4)
    );

    seq_divider #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dz8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push4(input int q, input int r, input bit dz, input int dd, input int dv);
        exp_t e;
        e.q = 8'(q); e.r = 8'(r); e.dz = dz; e.dd = 8'(dd); e.dv = 8'(dv);
        sb4.push_back(e);
    endtask

    task automatic push8(input int q, input int r, input bit dz, input int dd, input int dv);
        exp_t e;
        e.q = 8'(q); e.r = 8'(r); e.dz = dz; e.dd = 8'(dd); e.dv = 8'(dv);
        sb8.push_back(e);
    endtask

    // Called just after a negedge; returns at the first negedge after acceptance.
    task automatic issue4(input int dd, input int dv);
        dd4 = 4'(dd);
        dv4 = 4'(dv);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        dd4 = 4'hA;
        dv4 = 4'h0;
    endtask

    // n0/b0: negedges already elapsed since acceptance / busy negedges seen before now.
    task automatic wait_done4(input string name, input int n0, input int b0,
                              input int n_exp, input int b_exp);
        int n, b;
        bit seen;
        n = n0; b = b0; seen = 0;
        while (n < 40) begin
            if (busy4) b++;
            if (done4) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, n, n_exp);
        check({name, "_busy_cycles"}, b, b_exp);
    endtask

    task automatic op4(input string name, input int dd, input int dv,
                       input int q, input int r, input bit dz);
        push4(q, r, dz, dd, dv);
        issue4(dd, dv);
        wait_done4(name, 1, 0, dz ? 1 : 5, dz ? 0 : 4);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (sb4.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done4: got done=1 expected no result at %0t", $time);
            end else begin
                e4 = sb4.pop_front();
                check("quotient4", 32'(quotient4), 32'(e4.q));
                check("remainder4", 32'(remainder4), 32'(e4.r));
                check("div_by_zero4", 32'(dz4), 32'(e4.dz));
                if (!e4.dz) begin
                    check("invariant4", int'(quotient4) * int'(e4.dv) + int'(remainder4), int'(e4.dd));
                    check("rem_lt_div4", 32'(remainder4 < e4.dv[3:0]), 32'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done8: got done=1 expected no result at %0t", $time);
            end else begin
                e8 = sb8.pop_front();
                check("quotient8", 32'(quotient8), 32'(e8.q));
                check("remainder8", 32'(remainder8), 32'(e8.r));
                check("div_by_zero8", 32'(dz8), 32'(e8.dz));
                if (!e8.dz) begin
                    check("invariant8", int'(quotient8) * int'(e8.dv) + int'(remainder8), int'(e8.dd));
                    check("rem_lt_div8", 32'(remainder8 < e8.dv), 32'd1);
                end
            end
        end
    end

    initial begin
        int n;
        int dd, dv;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_quotient", 32'(quotient4), 0);
        check("rst_remainder", 32'(remainder4), 0);
        check("rst_dz", 32'(dz4), 0);
        rst = 1'b0;
        @(negedge clk);

        op4("d13_3", 13, 3, 4, 1, 0);
        op4("d15_1", 15, 1, 15, 0, 0);
        op4("d7_9", 7, 9, 0, 7, 0);
        op4("d0_5", 0, 5, 0, 0, 0);
        op4("d9_0", 9, 0, 15, 9, 1);
        check("hold_quotient", 32'(quotient4), 15);
        check("hold_remainder", 32'(remainder4), 9);

        // Start during RUN is ignored; start in the DONE cycle is accepted back-to-back.
        push4(4, 1, 0, 13, 3);
        issue4(13, 3);
        @(negedge clk);
        dd4 = 4'd2; dv4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4("ignore_mid_run", 3, 2, 5, 4);
        push4(3, 2, 0, 14, 4);
        issue4(14, 4);
        wait_done4("back_to_back", 1, 0, 5, 4);
        @(negedge clk);

        // Reset in the middle of 13/3 aborts with no done pulse.
        issue4(13, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy4), 0);
        check("abort_done", 32'(done4), 0);
        check("abort_quotient", 32'(quotient4), 0);
        check("abort_remainder", 32'(remainder4), 0);
        check("abort_dz", 32'(dz4), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        op4("d6_2", 6, 2, 3, 0, 0);

        // WIDTH=8 instance.
        push8(15, 15, 0, 255, 16);
        dd8 = 8'd255; dv8 = 8'd16; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", n, 9);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            dd = int'($urandom_range(0, 255));
            dv = int'($urandom_range(0, 255));
            if (dv == 0) push8(255, dd, 1, dd, dv);
            else push8(dd / dv, dd % dv, 0, dd, dv);
            dd8 = 8'(dd); dv8 = 8'(dv); start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            n = 1;
            while (!done8 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!done8) check("w8_rand_timeout", 32'(done8), 1);
            @(negedge clk);
        end

        check("sb4_drained", sb4.size(), 0);
        check("sb8_drained", sb8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
